// File: rtl/glyph_writer_pkg.sv
// Shared types for the glyph writer: FSM states, request operations and request priority helpers.
package glyph_writer_pkg;

  typedef enum logic [1:0] {StIdle, StUpdate, StWrcols, StDone} state_e;

  typedef enum logic [1:0] {OP_NONE, OP_INC, OP_DEC, OP_CLR} op_e;

  // Priority order: clr > inc > dec > none.
  function automatic logic [1:0] op_rank(input op_e op);
    case (op)
      OP_CLR:  return 2'd3;
      OP_INC:  return 2'd2;
      OP_DEC:  return 2'd1;
      default: return 2'd0;
    endcase
  endfunction

  function automatic op_e op_max(input op_e a, input op_e b);
    return (op_rank(b) > op_rank(a)) ? b : a;
  endfunction

  function automatic op_e req_op(input logic clr, input logic inc, input logic dec);
    if (clr) return OP_CLR;
    if (inc) return OP_INC;
    if (dec) return OP_DEC;
    return OP_NONE;
  endfunction

endpackage

// File: rtl/glyph_writer_if.sv
// Request/colour inputs and framebuffer write outputs of the glyph writer.
interface glyph_writer_if #(
  parameter int unsigned NUM_DIGITS     = 2,
  parameter int unsigned COLS_PER_GLYPH = 5,
  parameter int unsigned COLOR_W        = 4
);
  localparam int unsigned NCOLS  = NUM_DIGITS * COLS_PER_GLYPH;
  localparam int unsigned ADDR_W = (NCOLS > 1) ? $clog2(NCOLS) : 1;
  localparam int unsigned COL_W  = (COLS_PER_GLYPH > 1) ? $clog2(COLS_PER_GLYPH) : 1;

  logic               next_pulse;
  logic               prev_pulse;
  logic               clr_pulse;
  logic [COLOR_W-1:0] color;
  logic [ADDR_W-1:0]  fb_addr;
  logic [3:0]         glyph_val;
  logic [COL_W-1:0]   glyph_col;
  logic [COLOR_W-1:0] fb_we;
  logic               busy;
  logic               done;

  modport master (
    output next_pulse, prev_pulse, clr_pulse, color,
    input  fb_addr, glyph_val, glyph_col, fb_we, busy, done
  );

  modport slave (
    input  next_pulse, prev_pulse, clr_pulse, color,
    output fb_addr, glyph_val, glyph_col, fb_we, busy, done
  );
endinterface

// File: rtl/bcd_updown_counter.sv
// Multi-digit BCD value with increment/decrement (wrapping) and clear.
module bcd_updown_counter
  import glyph_writer_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  op_e                     op,
  output logic [4*NUM_DIGITS-1:0] value
);

  logic [4*NUM_DIGITS-1:0] value_d;
  logic                    carry;

  // Ripple the carry/borrow digit by digit; all-9s (or all-0s) wraps naturally.
  always_comb begin
    value_d = value;
    carry   = 1'b1;
    case (op)
      OP_CLR: value_d = '0;
      OP_INC: begin
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
          if (carry) begin
            if (value[4*i +: 4] == 4'd9) begin
              value_d[4*i +: 4] = 4'd0;
            end else begin
              value_d[4*i +: 4] = value[4*i +: 4] + 4'd1;
              carry = 1'b0;
            end
          end
        end
      end
      OP_DEC: begin
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
          if (carry) begin
            if (value[4*i +: 4] == 4'd0) begin
              value_d[4*i +: 4] = 4'd9;
            end else begin
              value_d[4*i +: 4] = value[4*i +: 4] - 4'd1;
              carry = 1'b0;
            end
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
    end else begin
      value <= value_d;
    end
  end

endmodule

// File: rtl/glyph_writer_fsm.sv
// Refreshes a BCD number into framebuffer columns, one column per cycle, on inc/dec/clr requests.
module glyph_writer_fsm
  import glyph_writer_pkg::*;
#(
  parameter int unsigned NUM_DIGITS     = 2,
  parameter int unsigned COLS_PER_GLYPH = 5,
  parameter int unsigned COLOR_W        = 4
) (
  input logic           clk,
  input logic           rst_n,
  glyph_writer_if.slave bus
);

  localparam int unsigned NCOLS  = NUM_DIGITS * COLS_PER_GLYPH;
  localparam int unsigned ADDR_W = (NCOLS > 1) ? $clog2(NCOLS) : 1;
  localparam int unsigned COL_W  = (COLS_PER_GLYPH > 1) ? $clog2(COLS_PER_GLYPH) : 1;
  localparam int unsigned DIG_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  state_e                  state_q;
  op_e                     pending_q;
  logic [ADDR_W-1:0]       addr_q;
  logic [COL_W-1:0]        gcol_q;
  logic [DIG_W-1:0]        gdig_q;
  logic [4*NUM_DIGITS-1:0] value;
  op_e                     new_req;
  op_e                     merged;
  op_e                     cnt_op;
  logic                    wr;

  assign new_req = req_op(bus.clr_pulse, bus.next_pulse, bus.prev_pulse);
  assign merged  = op_max(pending_q, new_req);
  assign cnt_op  = (state_q == StUpdate) ? pending_q : OP_NONE;

  bcd_updown_counter #(
    .NUM_DIGITS(NUM_DIGITS)
  ) u_counter (
    .clk  (clk),
    .rst_n(rst_n),
    .op   (cnt_op),
    .value(value)
  );

  // Reset parks in WRCOLS so release starts the power-up clear at column 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StWrcols;
      pending_q <= OP_NONE;
      addr_q    <= '0;
      gcol_q    <= '0;
      gdig_q    <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          pending_q <= merged;
          if (merged != OP_NONE) state_q <= StUpdate;
        end
        StUpdate: begin
          pending_q <= new_req;
          addr_q    <= '0;
          gcol_q    <= '0;
          gdig_q    <= '0;
          state_q   <= StWrcols;
        end
        StWrcols: begin
          pending_q <= merged;
          addr_q    <= addr_q + 1'b1;
          if (gcol_q == COL_W'(COLS_PER_GLYPH - 1)) begin
            gcol_q <= '0;
            gdig_q <= gdig_q + 1'b1;
          end else begin
            gcol_q <= gcol_q + 1'b1;
          end
          if (addr_q == ADDR_W'(NCOLS - 1)) state_q <= StDone;
        end
        StDone: begin
          pending_q <= merged;
          state_q   <= (merged != OP_NONE) ? StUpdate : StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign wr = (state_q == StWrcols);

  always_comb begin
    bus.fb_we     = wr ? bus.color : '0;
    bus.fb_addr   = wr ? addr_q : '0;
    bus.glyph_col = wr ? gcol_q : '0;
    bus.busy      = wr || (state_q == StUpdate);
    bus.done      = (state_q == StDone);
    bus.glyph_val = 4'd0;
    // Region k shows digit NUM_DIGITS-1-k so the most significant digit sits leftmost.
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (wr && (i == int'(NUM_DIGITS) - 1 - int'(gdig_q))) bus.glyph_val = value[4*i +: 4];
    end
  end

endmodule
